// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants
package riscv_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_e;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two synchronous FIFO of fetched {pc, instr} entries
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             din,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rptr, wptr, widx;
  // a push in a clearing cycle lands in slot 0 of the emptied buffer
  assign widx = clear ? '0 : wptr;
  assign head = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      rptr  <= '0;
      wptr  <= AW'(push);
      count <= (AW+1)'(push);
    end else begin
      wptr  <= wptr + AW'(push);
      rptr  <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[widx] <= din;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, single-outstanding imem requester and IF/ID register
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_en_i,
  input  logic        if_en_i,
  input  logic        flush_i,
  input  logic        pc_src_i,
  input  logic [63:0] branch_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic        valid_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e state, state_next;
  logic [63:0] fetch_pc, drain_addr;
  logic [CW-1:0] count, count_next;
  fetch_entry_t head;
  logic handshake, good, clear, pop, bypass, push, space;
  assign imem_req_o  = state != IDLE;
  assign imem_addr_o = state == DRAIN ? drain_addr : fetch_pc;
  assign handshake   = imem_req_o & imem_ack_i;
  assign good        = handshake & (state == REQ) & ~pc_src_i;
  assign clear       = pc_src_i | flush_i;
  assign pop         = if_en_i & ~clear & (count != '0);
  assign bypass      = if_en_i & ~clear & (count == '0) & good;
  assign push        = good & ~bypass;
  // the request issued next cycle must find a free slot after this cycle's push/pop
  assign count_next  = clear ? CW'(push) : count + CW'(push) - CW'(pop);
  assign space       = pc_en_i & (count_next < CW'(FIFO_DEPTH));
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   ({fetch_pc, imem_rdata_i}),
    .count (count),
    .head  (head)
  );
  always_comb begin
    state_next = (state == IDLE || handshake) ? (space ? REQ : IDLE)
               : (pc_src_i ? DRAIN : state);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc   <= RESET_PC & ~64'h3;
      drain_addr <= RESET_PC & ~64'h3;
      instr_o    <= NOP_INSTR;
      pc_o       <= '0;
      valid_o    <= 1'b0;
    end else begin
      fetch_pc <= pc_src_i ? (branch_pc_i & ~64'h3) : good ? fetch_pc + 64'd4 : fetch_pc;
      if (state != DRAIN) drain_addr <= fetch_pc;
      if (clear) begin
        instr_o <= NOP_INSTR;
        valid_o <= 1'b0;
      end else if (pop) begin
        pc_o    <= head.pc;
        instr_o <= head.instr;
        valid_o <= 1'b1;
      end else if (bypass) begin
        pc_o    <= fetch_pc;
        instr_o <= imem_rdata_i;
        valid_o <= 1'b1;
      end else if (if_en_i) begin
        instr_o <= NOP_INSTR;
        valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table, corner sequences and random run against a queue model
module tb_instruction_fetch;
  import riscv_pkg::*;
  localparam logic [63:0] RPC = 64'h1000;
  localparam int DEPTH = 2;
  localparam logic [31:0] N = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst, pc_en, if_en, flush, pc_src, ack, req, valid;
  logic [63:0] branch_pc, addr, pc;
  logic [31:0] rdata, instr;
  int checks = 0;
  int failures = 0;
  instruction_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .pc_en_i(pc_en), .if_en_i(if_en), .flush_i(flush),
    .pc_src_i(pc_src), .branch_pc_i(branch_pc), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_rdata_i(rdata), .instr_o(instr), .pc_o(pc), .valid_o(valid)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic rst, pe, ie, fl, ps;
    logic [63:0] br;
    logic ack;
    logic [31:0] rd;
    logic ereq;
    logic [63:0] eaddr;
    logic ev;
    logic [31:0] ei;
    logic [63:0] epc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic r, pe, ie, fl, ps, input logic [63:0] br, input logic a,
                             input logic [31:0] rd, input logic ereq, input logic [63:0] eaddr,
                             input logic ev, input logic [31:0] ei, input logic [63:0] epc);
    vec_t t;
    t.rst = r; t.pe = pe; t.ie = ie; t.fl = fl; t.ps = ps; t.br = br; t.ack = a; t.rd = rd;
    t.ereq = ereq; t.eaddr = eaddr; t.ev = ev; t.ei = ei; t.epc = epc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, pe, ie, fl, ps, input logic [63:0] br, input logic a,
                       input logic [31:0] rd);
    rst = r; pc_en = pe; if_en = ie; flush = fl; pc_src = ps; branch_pc = br; ack = a; rdata = rd;
  endtask

  task automatic chk_out(input string tag, input logic ereq, input logic [63:0] eaddr,
                         input logic ev, input logic [31:0] ei, input logic [63:0] epc);
    chk({tag, " req"}, req, ereq);
    if (ereq) chk({tag, " addr"}, addr, eaddr);
    chk({tag, " valid"}, valid, ev);
    chk({tag, " instr"}, instr, ei);
    chk({tag, " pc"}, pc, epc);
  endtask

  // reference model: outstanding request + queue of buffered words + output register
  logic [63:0] m_pc, m_addr, m_opc;
  logic [31:0] m_oinstr;
  logic m_ov, m_busy, m_stale;
  fetch_entry_t q[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_addr = RPC; m_opc = '0; m_oinstr = N; m_ov = 1'b0;
    m_busy = 1'b0; m_stale = 1'b0; q.delete();
  endtask

  task automatic model_step();
    fetch_entry_t e, h;
    logic hs, good;
    if (rst) begin
      model_reset();
      return;
    end
    hs = m_busy && ack;
    good = hs && !m_stale && !pc_src;
    e.pc = m_pc; e.instr = rdata;
    if (pc_src || flush) begin
      q.delete();
      if (good) q.push_back(e);
      m_oinstr = N; m_ov = 1'b0;
    end else if (if_en) begin
      if (q.size() > 0) begin
        h = q.pop_front();
        m_opc = h.pc; m_oinstr = h.instr; m_ov = 1'b1;
        if (good) q.push_back(e);
      end else if (good) begin
        m_opc = e.pc; m_oinstr = e.instr; m_ov = 1'b1;
      end else begin
        m_oinstr = N; m_ov = 1'b0;
      end
    end else if (good) q.push_back(e);
    m_pc = pc_src ? (branch_pc & ~64'h3) : good ? m_pc + 64'd4 : m_pc;
    if (hs) begin
      m_busy = 1'b0; m_stale = 1'b0;
    end else if (m_busy && pc_src) m_stale = 1'b1;
    if (!m_busy && pc_en && q.size() < DEPTH) begin
      m_busy = 1'b1; m_addr = m_pc;
    end
  endtask

  initial begin
    int mem_left;
    bit mem_active;
    logic a;
    logic [63:0] br;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    //        rst pe ie fl ps br                     ack rd        req addr                   v  instr     pc
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0,          0, 64'h1000, 0, N, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,          1, 64'h1000, 0, N, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'hA0,     1, 64'h1004, 1, 32'hA0, 64'h1000));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'hA1,     1, 64'h1008, 1, 32'hA1, 64'h1004));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 32'hA2,     1, 64'h100C, 1, 32'hA1, 64'h1004));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 32'hA3,     0, 0,        1, 32'hA1, 64'h1004));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,          0, 0,        1, 32'hA1, 64'h1004));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,          1, 64'h1010, 1, 32'hA2, 64'h1008));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,          1, 64'h1010, 1, 32'hA3, 64'h100C));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,          1, 64'h1010, 0, N, 64'h100C));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'hA4,     1, 64'h1014, 1, 32'hA4, 64'h1010));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 32'hA5,     1, 64'h1018, 1, 32'hA4, 64'h1010));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 32'hA6,     0, 0,        1, 32'hA4, 64'h1010));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 0,          1, 64'h101C, 0, N, 64'h1010));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'hA7,     1, 64'h1020, 1, 32'hA7, 64'h101C));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,          1, 64'h1020, 0, N, 64'h101C));
    tbl.push_back(v(0, 1, 1, 0, 1, 64'h2002, 0, 0,   1, 64'h1020, 0, N, 64'h101C));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,          1, 64'h1020, 0, N, 64'h101C));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'hDEAD,   1, 64'h2000, 0, N, 64'h101C));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'hB0,     1, 64'h2004, 1, 32'hB0, 64'h2000));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 32'hB1,     0, 0,        1, 32'hB1, 64'h2004));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0,          0, 0,        0, N, 64'h2004));
    tbl.push_back(v(0, 1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, N, 64'h2004));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'hC0,     1, 64'h0,    1, 32'hC0, 64'hFFFF_FFFF_FFFF_FFFC));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'hC1,     1, 64'h4,    1, 32'hC1, 64'h0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,          1, 64'h4,    0, N, 64'h0));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0,          0, 0,        0, N, 64'h0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'hEE,     1, 64'h1000, 0, N, 64'h0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'hD0,     1, 64'h1004, 1, 32'hD0, 64'h1000));
    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].pe, tbl[i].ie, tbl[i].fl, tbl[i].ps, tbl[i].br, tbl[i].ack, tbl[i].rd);
      @(negedge clk);
      chk_out($sformatf("row%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].ev, tbl[i].ei, tbl[i].epc);
    end
    // redirect coinciding with ack: word dropped, no drain
    drive(0, 1, 1, 0, 1, 64'h3000, 1, 32'hFF);
    @(negedge clk);
    chk_out("redir_ack", 1, 64'h3000, 0, N, 64'h1000);
    drive(0, 1, 1, 0, 0, 0, 1, 32'hF1);
    @(negedge clk);
    chk_out("redir_ack_next", 1, 64'h3004, 1, 32'hF1, 64'h3000);
    // second redirect while draining keeps the stale address on the bus
    drive(0, 1, 1, 0, 1, 64'h4000, 0, 0);
    @(negedge clk);
    chk_out("drain1", 1, 64'h3004, 0, N, 64'h3000);
    drive(0, 1, 1, 0, 1, 64'h5000, 0, 0);
    @(negedge clk);
    chk_out("drain2", 1, 64'h3004, 0, N, 64'h3000);
    drive(0, 1, 1, 0, 0, 0, 1, 32'hBAD);
    @(negedge clk);
    chk_out("drain_done", 1, 64'h5000, 0, N, 64'h3000);
    drive(0, 1, 1, 0, 0, 0, 1, 32'h51);
    @(negedge clk);
    chk_out("drain_fetch", 1, 64'h5004, 1, 32'h51, 64'h5000);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    mem_active = 0;
    mem_left = 0;
    @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      chk_out($sformatf("rnd%0d", c), m_busy, m_addr, m_ov, m_oinstr, m_opc);
      if (req) begin
        if (!mem_active) begin
          mem_active = 1;
          mem_left = $urandom_range(0, 3);
        end
        a = (mem_left == 0);
      end else begin
        mem_active = 0;
        a = ($urandom_range(0, 19) == 0);
      end
      if (req && a) mem_active = 0;
      else if (mem_active) mem_left--;
      br = $urandom_range(0, 3) == 0 ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                     : {$urandom, $urandom};
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0, br, a,
            req ? mem_word(addr) : $urandom);
      model_step();
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
